// File: rtl/ldpc_mem_pkg.sv
// Shared decoder-memory definitions: default RAM geometry, the arbiter
// ownership states and the pending-read record.
package ldpc_mem_pkg;

    // Three 5-bit LLR lanes per word, 256 words.
    localparam int unsigned DATA_WIDTH_DEF = 15;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    // IDLE arbitrates round-robin; OWNx means port x holds a locked burst.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // A granted read whose data arrives from the RAM on the next cycle.
    typedef struct packed {
        logic valid;
        logic port;
    } pend_rd_t;

endpackage

// File: rtl/ext_ram_arbiter_if.sv
// Bus between the two requesters, the arbiter and the external RAM.
//   requester 0/1 : req, we, addr, wdata, lock  -> arbiter
//                   gnt, rvalid, rdata          <- arbiter
//   RAM           : ram_address, ram_data_in, ram_we, ram_cs <- arbiter
//                   ram_data_out (sync read, 1 cycle after cs) -> arbiter
// Modport slave is the arbiter's view, master the environment's view.
interface ext_ram_arbiter_if
    import ldpc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  lock0, lock1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_we;
    logic                  ram_cs;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  ram_data_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output ram_address, ram_data_in, ram_we, ram_cs
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output ram_data_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  ram_address, ram_data_in, ram_we, ram_cs
    );
endinterface

// File: rtl/ext_ram_arbiter_rr_arb2.sv
// Two-way round-robin pick.
//   req0/req1  : requests
//   last_grant : port granted most recently
//   pick0/pick1: one-hot (or zero) choice; on conflict the port that was
//                not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick0,
    output logic pick1
);
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req0 && req1) begin
            pick0 = last_grant;
            pick1 = ~last_grant;
        end else begin
            pick0 = req0;
            pick1 = req1;
        end
    end
endmodule

// File: rtl/ext_ram_arbiter.sv
// Arbiter sharing one synchronous external RAM between the variable-node
// (port 0) and check-node (port 1) requesters.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : requester handshakes, read returns and RAM drive (slave view)
// Grants are combinational and steer the RAM in the same cycle; read data
// returns on rvalid one cycle after the grant. A grant with lock held keeps
// ownership until that port drops req or lock.
module ext_ram_arbiter
    import ldpc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    ext_ram_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    pend_rd_t   pend_q, pend_d;

    logic                  pick0, pick1;
    logic                  gnt0, gnt1;
    logic                  ram_cs, ram_we;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  rvalid0, rvalid1;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant_q),
        .pick0      (pick0),
        .pick1      (pick1)
    );

    // The exiting cycle of a burst is still arbitrated as OWNx, so the other
    // port only gets in on the following cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            IDLE: begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
            OWN0:    gnt0 = bus.req0;
            OWN1:    gnt1 = bus.req1;
            default: ;
        endcase
        // Grants are combinational, so they need explicit masking in reset.
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && bus.lock0)      state_d = OWN0;
                else if (gnt1 && bus.lock1) state_d = OWN1;
            end
            OWN0:    if (!bus.req0 || !bus.lock0) state_d = IDLE;
            OWN1:    if (!bus.req1 || !bus.lock1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (gnt0)      last_grant_d = 1'b0;
        else if (gnt1) last_grant_d = 1'b1;
        pend_d.valid = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
        pend_d.port  = gnt1;
    end

    always_comb begin
        ram_cs      = gnt0 | gnt1;
        ram_we      = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        if (gnt0) begin
            ram_we      = bus.we0;
            ram_address = bus.addr0;
            ram_data_in = bus.wdata0;
        end else if (gnt1) begin
            ram_we      = bus.we1;
            ram_address = bus.addr1;
            ram_data_in = bus.wdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
        end
    end

    assign rvalid0 = pend_q.valid && !pend_q.port;
    assign rvalid1 = pend_q.valid &&  pend_q.port;

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.ram_cs      = ram_cs;
    assign bus.ram_we      = ram_we;
    assign bus.ram_address = ram_address;
    assign bus.ram_data_in = ram_data_in;
    assign bus.rvalid0     = rvalid0;
    assign bus.rvalid1     = rvalid1;
    assign bus.rdata0      = rvalid0 ? bus.ram_data_out : '0;
    assign bus.rdata1      = rvalid1 ? bus.ram_data_out : '0;
endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Self-checking bench for ext_ram_arbiter: a synchronous RAM model, a
// per-cycle reference model of the arbitration rules with a memory image,
// and directed scenarios with hand-computed expectations.
module tb_ext_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ext_ram_arbiter_if #(.DATA_WIDTH(15), .ADDR_WIDTH(8)) bus ();

    ext_ram_arbiter #(.DATA_WIDTH(15), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [14:0] init_word(input int a);
        return 15'h4000 | 15'(a);
    endfunction

    // External synchronous RAM.
    logic [14:0] ram_mem [256];
    initial for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_data_in;
            else            bus.ram_data_out <= ram_mem[bus.ram_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_owner;     // -1 none, else port holding a locked burst
    logic        m_last;      // port granted most recently
    logic        m_rv [2];    // read return expected this cycle
    logic [14:0] m_rd [2];
    logic [14:0] m_mem [256];
    logic        rst_seen = 1'b0;
    logic        eg0, eg1, ecs, ewe;
    logic [7:0]  ea;
    logic [14:0] ed;
    int          gp;

    initial for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);

    always @(posedge rst) rst_seen = 1'b1;

    task automatic model_reset;
        m_owner  = -1;
        m_last   = 1'b1;
        m_rv[0]  = 1'b0;
        m_rv[1]  = 1'b0;
        rst_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("rst_gnt0", bus.gnt0, 0);
            chk("rst_gnt1", bus.gnt1, 0);
            chk("rst_rvalid0", bus.rvalid0, 0);
            chk("rst_rvalid1", bus.rvalid1, 0);
            chk("rst_rdata0", bus.rdata0, 0);
            chk("rst_rdata1", bus.rdata1, 0);
            chk("rst_ram_cs", bus.ram_cs, 0);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_address", bus.ram_address, 0);
            chk("rst_ram_data_in", bus.ram_data_in, 0);
        end else begin
            if (rst_seen) model_reset();
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (m_owner == 0)                 eg0 = bus.req0;
            else if (m_owner == 1)            eg1 = bus.req1;
            else if (bus.req0 && bus.req1) begin
                if (m_last) eg0 = 1'b1; else eg1 = 1'b1;
            end else begin
                eg0 = bus.req0;
                eg1 = bus.req1;
            end
            gp = eg0 ? 0 : (eg1 ? 1 : -1);
            ecs = (gp >= 0);
            ewe = 1'b0; ea = '0; ed = '0;
            if (gp == 0) begin ewe = bus.we0; ea = bus.addr0; ed = bus.wdata0; end
            if (gp == 1) begin ewe = bus.we1; ea = bus.addr1; ed = bus.wdata1; end

            chk("mdl_gnt0", bus.gnt0, eg0);
            chk("mdl_gnt1", bus.gnt1, eg1);
            chk("mdl_ram_cs", bus.ram_cs, ecs);
            chk("mdl_ram_we", bus.ram_we, ewe);
            chk("mdl_ram_address", bus.ram_address, ea);
            chk("mdl_ram_data_in", bus.ram_data_in, ed);
            chk("mdl_rvalid0", bus.rvalid0, m_rv[0]);
            chk("mdl_rvalid1", bus.rvalid1, m_rv[1]);
            chk("mdl_rdata0", bus.rdata0, m_rv[0] ? m_rd[0] : 15'h0);
            chk("mdl_rdata1", bus.rdata1, m_rv[1] ? m_rd[1] : 15'h0);

            // Advance to the state after the coming edge.
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            if (m_owner >= 0) begin
                if (m_owner == 0 ? (!bus.req0 || !bus.lock0) : (!bus.req1 || !bus.lock1))
                    m_owner = -1;
            end else if (gp >= 0) begin
                if (gp == 0 ? bus.lock0 : bus.lock1) m_owner = gp;
            end
            if (gp >= 0) begin
                m_last = (gp == 1);
                if (ewe) m_mem[ea] = ed;
                else begin
                    m_rv[gp] = 1'b1;
                    m_rd[gp] = m_mem[ea];
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0,
                         input logic [14:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [7:0] a1,
                         input logic [14:0] d1, input logic l1);
        @(posedge clk);
        #1;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 8'h00, 15'h0, 0, 0, 0, 8'h00, 15'h0, 0);
    endtask

    int cnt0, cnt1;

    initial begin
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01; bus.wdata0 = '0; bus.lock0 = 1'b0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0;    bus.wdata1 = '0; bus.lock1 = 1'b0;
        settle();
        chk("reset_gnt0_masked", bus.gnt0, 0);
        chk("reset_ram_cs", bus.ram_cs, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0 = 1'b0;

        // Simultaneous write (port 0) and read (port 1) after reset.
        drive(1, 1, 8'h05, 15'h0123, 0, 1, 0, 8'h06, 15'h0, 0);
        settle();
        chk("t33_gnt0", bus.gnt0, 1);
        chk("t33_ram_we", bus.ram_we, 1);
        chk("t33_ram_address", bus.ram_address, 8'h05);
        drive(0, 0, 8'h00, 15'h0, 0, 1, 0, 8'h06, 15'h0, 0);
        settle();
        chk("t33_gnt1", bus.gnt1, 1);
        idle();
        settle();
        chk("t33_rvalid1", bus.rvalid1, 1);
        chk("t33_rdata1", bus.rdata1, 15'h4006);

        // Write then read back across ports.
        drive(1, 1, 8'h10, 15'h5A5A, 0, 0, 0, 8'h00, 15'h0, 0);
        drive(0, 0, 8'h00, 15'h0, 0, 1, 0, 8'h10, 15'h0, 0);
        settle();
        chk("t34_gnt1", bus.gnt1, 1);
        idle();
        settle();
        chk("t34_rvalid1", bus.rvalid1, 1);
        chk("t34_rdata1", bus.rdata1, 15'h5A5A);
        chk("t34_rvalid0", bus.rvalid0, 0);

        // Continuous unlocked conflict alternates, port 0 first.
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 8'(8'h60 + i), 15'h0, 0, 1, 0, 8'(8'h70 + i), 15'h0, 0);
            settle();
            chk("t35_gnt0", bus.gnt0, (i % 2) == 0);
            chk("t35_gnt1", bus.gnt1, (i % 2) == 1);
            cnt0 += int'(bus.gnt0);
            cnt1 += int'(bus.gnt1);
        end
        chk("t35_count0", cnt0, 4);
        chk("t35_count1", cnt1, 4);
        idle();

        // Locked 4-word burst on port 1 while port 0 waits.
        drive(0, 0, 8'h30, 15'h0, 0, 1, 0, 8'h20, 15'h0, 1);
        settle();
        chk("t36_gnt1_w0", bus.gnt1, 1);
        for (int i = 1; i < 4; i++) begin
            drive(1, 0, 8'h30, 15'h0, 0, 1, 0, 8'(8'h20 + i), 15'h0, i != 3);
            settle();
            chk("t36_gnt1_burst", bus.gnt1, 1);
            chk("t36_gnt0_held", bus.gnt0, 0);
            chk("t36_ram_address", bus.ram_address, 8'(8'h20 + i));
        end
        drive(1, 0, 8'h30, 15'h0, 0, 0, 0, 8'h00, 15'h0, 0);
        settle();
        chk("t36_gnt0_after", bus.gnt0, 1);
        idle();

        // Asynchronous reset pulse while a port 0 read is pending.
        drive(1, 0, 8'h40, 15'h0, 0, 0, 0, 8'h00, 15'h0, 0);
        settle();
        chk("t37_gnt0", bus.gnt0, 1);
        drive(1, 0, 8'h42, 15'h0, 0, 1, 0, 8'h41, 15'h0, 0);
        #1 rst = 1'b1;
        #1;
        chk("t37_rst_gnt0", bus.gnt0, 0);
        chk("t37_rst_gnt1", bus.gnt1, 0);
        chk("t37_rst_rvalid0", bus.rvalid0, 0);
        chk("t37_rst_ram_cs", bus.ram_cs, 0);
        #1 rst = 1'b0;
        settle();
        chk("t37_no_rvalid0", bus.rvalid0, 0);
        chk("t37_idle_port0_wins", bus.gnt0, 1);
        idle();

        // Back-to-back reads at the address extremes.
        drive(1, 1, 8'hFF, 15'h1111, 0, 0, 0, 8'h00, 15'h0, 0);
        drive(0, 0, 8'h00, 15'h0, 0, 1, 1, 8'h00, 15'h2222, 0);
        drive(1, 0, 8'hFF, 15'h0, 0, 0, 0, 8'h00, 15'h0, 0);
        drive(1, 0, 8'h00, 15'h0, 0, 0, 0, 8'h00, 15'h0, 0);
        settle();
        chk("t38_rvalid0_a", bus.rvalid0, 1);
        chk("t38_rdata0_a", bus.rdata0, 15'h1111);
        idle();
        settle();
        chk("t38_rvalid0_b", bus.rvalid0, 1);
        chk("t38_rdata0_b", bus.rdata0, 15'h2222);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ext_ram_arbiter.md
EXT_RAM_ARBITER -- requirements
Module: ext_ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 15, the RAM word width (three 5-bit LLR lanes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the RAM address width (256 words).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1, access request from requester 0 (variable-node side) and requester 1 (check-node side).
REQ-006 SHALL have ports we0/we1, input, 1, 1 = write and 0 = read, qualified by req.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_WIDTH, the word address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_WIDTH, the write data.
REQ-009 SHALL have ports lock0/lock1, input, 1, which hold ownership for a burst while asserted together with req.
REQ-010 SHALL have ports gnt0/gnt1, output, 1, meaning the request is accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1, meaning read data is valid this cycle.
REQ-012 SHALL have ports rdata0/rdata1, output, DATA_WIDTH, the read data.
REQ-013 SHALL have ports ram_address (ADDR_WIDTH), ram_data_in (DATA_WIDTH), ram_we (1) and ram_cs (1), all outputs, driving the external RAM.
REQ-014 SHALL have port ram_data_out, input, DATA_WIDTH, the synchronous RAM read data, valid one cycle after cs.

Function
REQ-015 SHALL implement the states IDLE, OWN0 and OWN1, plus a last_grant register used for round-robin.
REQ-016 SHALL assert at most one gnt per cycle; gnt is combinational from req, lock, state and last_grant.
REQ-017 In IDLE with a single req: SHALL grant that requester.
REQ-018 In IDLE with both reqs: SHALL grant the requester not equal to last_grant.
REQ-019 On any grant to port i: SHALL set last_grant=i at the clock edge.
REQ-020 On a grant with lock_i=1: SHALL enter OWN_i at the clock edge.
REQ-021 In OWN_i: SHALL grant only port i while req_i=1, even if the other req is asserted.
REQ-022 In OWN_i: SHALL return to IDLE at the edge where req_i=0 or lock_i=0. That cycle is still arbitrated as OWN_i: a req_i=1 with lock_i=0 is granted (last cycle of the burst), and the other port is not granted until the next cycle.
REQ-023 SHALL drive ram_cs=gnt0|gnt1, ram_we=the granted port's we, and ram_address/ram_data_in=the granted port's addr/wdata in the same cycle; when there is no grant, all RAM outputs SHALL be 0.
REQ-024 For a granted read on port i: SHALL assert rvalid_i exactly one cycle later with rdata_i=ram_data_out, via a 1-cycle pending-read register holding valid and port id.
REQ-025 SHALL drive rdata of a non-valid port to 0; writes SHALL produce no rvalid.
REQ-026 Back-to-back reads SHALL be supported at one per cycle with no bubbles; latency is 1 cycle from gnt to rvalid.
REQ-027 A requester SHALL hold req/we/addr/wdata stable until gnt; an ungranted request waits without loss.
REQ-028 Starvation bound: with both requesters continuously requesting and unlocked, grants SHALL alternate every cycle.

Reset
REQ-029 While rst=1 (asynchronous): state=IDLE, last_grant=1 (port 0 wins the first conflict), pending-read valid=0, and all gnt/rvalid/rdata/ram_* outputs=0.
REQ-030 A reset asserted mid-burst or with a read pending SHALL abort it with no rvalid issued afterwards; operation resumes from IDLE on the first edge after release.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, OWN0=1, OWN1=2) and DATA_WIDTH/ADDR_WIDTH defaults in the shared decoder package ldpc_mem_pkg.
REQ-032 SHALL contain one sub-module, rr_arb2 (2-way round-robin pick from req and last_grant); everything else SHALL be flat.

Verification
REQ-033 Reset then req0 write and req1 read in the same cycle -> gnt0=1, ram_we=1, ram_address=addr0; next cycle gnt1=1, and rvalid1=1 one cycle later.
REQ-034 Port 0 writes 0x5A5A to addr 0x10; port 1 then reads 0x10 -> rvalid1=1 with rdata1=0x5A5A exactly 1 cycle after gnt1.
REQ-035 Both ports request continuously for 8 cycles, unlocked -> gnt alternates 0,1,0,1,... with 4 grants each.
REQ-036 Port 1 runs a locked 4-word burst (addr 0x20-0x23) while req0 is held -> gnt1 for 4 consecutive cycles, then gnt0 the cycle after lock1 drops.
REQ-037 rst is pulsed asynchronously in the cycle after a port 0 read grant -> rvalid0 never asserts, all outputs are 0 and the state is IDLE.
REQ-038 Read at addr 0xFF then addr 0x00 back-to-back -> two consecutive rvalid cycles with the correct data and no bubble.
